writeback_demux: RTL and testbench

WRITEBACK_DEMUX -- requirements
Module: writeback_demux

---
 rtl/writeback_demux.sv | 105 ++++++++++
 tb/tb_writeback_demux.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_demux.sv
// Write-back demultiplexer: a 2-entry in-order queue of pending register writes.
// The head entry drives one-hot write enables, and pending entries forward data to the operand path.
module writeback_demux #(
    parameter int WIDTH = 64,
    parameter int NREG  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_addr,
    input  logic [WIDTH-1:0] in_data,
    input  logic             rf_stall,
    output logic [NREG-1:0]  we,
    output logic [WIDTH-1:0] wdata,
    input  logic [4:0]       rd_addr,
    output logic             fwd_hit,
    output logic [WIDTH-1:0] fwd_data,
    output logic [1:0]       count
);

    localparam logic [4:0] XZR = 5'd31;

    logic [4:0]       addr_q [2];
    logic [WIDTH-1:0] data_q [2];
    logic [1:0]       count_q;
    logic [WIDTH-1:0] wdata_q;

    logic       accept;
    logic       issue;
    logic       wr_fire;
    logic       wr_idx;
    logic       v0;
    logic       v1;
    logic [1:0] count_n;

    assign v0       = (count_q != 2'd0);
    assign v1       = (count_q == 2'd2);
    assign in_ready = !reset && (count_q != 2'd2);
    assign accept   = in_valid && in_ready;
    assign issue    = !reset && v0 && !rf_stall;
    // XZR entries retire as an issue but never raise a write enable.
    assign wr_fire  = issue && (addr_q[0] != XZR);
    // The new tail slot, taking account of the head leaving on this same edge.
    assign wr_idx   = (count_q == 2'd1) && !issue;
    assign count    = count_q;

    always_comb begin
        count_n = count_q;
        if (accept && !issue) begin
            count_n = count_q + 2'd1;
        end else if (issue && !accept) begin
            count_n = count_q - 2'd1;
        end
    end

    always_comb begin
        we    = '0;
        wdata = wdata_q;
        if (wr_fire) begin
            we    = {{(NREG-1){1'b0}}, 1'b1} << addr_q[0];
            wdata = data_q[0];
        end
    end

    // The newest match wins, so slot 1 (tail when full) is checked first.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (!reset && rd_addr != XZR) begin
            if (v1 && addr_q[1] == rd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[1];
            end else if (v0 && addr_q[0] == rd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
            wdata_q <= '0;
        end else begin
            count_q <= count_n;
            if (wr_fire) begin
                wdata_q <= data_q[0];
            end
        end
    end

    // NOTE: queue payload needs no reset; count_q alone says which slots are valid.
    always_ff @(posedge clk) begin
        if (issue) begin
            addr_q[0] <= addr_q[1];
            data_q[0] <= data_q[1];
        end
        if (accept) begin
            addr_q[wr_idx] <= in_addr;
            data_q[wr_idx] <= in_data;
        end
    end

endmodule

// File: tb/tb_writeback_demux.sv
// Directed self-checking bench for writeback_demux: reset, issue, stall, XZR,
// forwarding, mid-queue reset and streaming scenarios.
module tb_writeback_demux;

    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_addr;
    logic [WIDTH-1:0] in_data;
    logic             rf_stall;
    logic [31:0]      we;
    logic [WIDTH-1:0] wdata;
    logic [4:0]       rd_addr;
    logic             fwd_hit;
    logic [WIDTH-1:0] fwd_data;
    logic [1:0]       count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    writeback_demux #(.WIDTH(WIDTH), .NREG(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .rf_stall (rf_stall),
        .we       (we),
        .wdata    (wdata),
        .rd_addr  (rd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
        .count    (count)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_addr = 5'd4; in_data = 64'h55;
        rf_stall = 1'b0; rd_addr = 5'd4;
        step();
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || we !== 32'h0 || fwd_hit !== 1'b0 || fwd_data !== 64'h0) begin
            bad++;
            $display("FAIL reset_outputs: in_ready=%b we=%h fwd_hit=%b fwd_data=%h, required 0/0/0/0",
                     in_ready, we, fwd_hit, fwd_data);
        end
        step();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || count !== 2'd0 || wdata !== 64'h0 || we !== 32'h0) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b count=%0d wdata=%h we=%h, required 1/0/0/0",
                     in_ready, count, wdata, we);
        end
        step();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_addr = 5'd5; in_data = 64'hAB; rf_stall = 1'b0;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (we !== 32'h0000_0020 || wdata !== 64'hAB || count !== 2'd1) begin
            bad++;
            $display("FAIL single_issue: we=%h wdata=%h count=%0d, required 00000020/ab/1", we, wdata, count);
        end
        step();
        @(negedge clk);
        total++;
        if (we !== 32'h0 || wdata !== 64'hAB || count !== 2'd0) begin
            bad++;
            $display("FAIL single_drain: we=%h wdata=%h count=%0d, required 0/ab/0", we, wdata, count);
        end
    endtask

    task automatic test_stall_fill();
        step();
        rf_stall = 1'b1;
        in_valid = 1'b1; in_addr = 5'd3; in_data = 64'h33;
        step();
        in_addr = 5'd7; in_data = 64'h77;
        step();
        in_addr = 5'd12; in_data = 64'hCC;
        @(negedge clk);
        total++;
        if (count !== 2'd2 || in_ready !== 1'b0 || we !== 32'h0) begin
            bad++;
            $display("FAIL stall_full: count=%0d in_ready=%b we=%h, required 2/0/0", count, in_ready, we);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (count !== 2'd2 || we !== 32'h0) begin
            bad++;
            $display("FAIL stall_hold: count=%0d we=%h, required 2/0", count, we);
        end
        rf_stall = 1'b0;
        #1;
        total++;
        if (we !== 32'h8 || wdata !== 64'h33) begin
            bad++;
            $display("FAIL stall_drain0: we=%h wdata=%h, required 8/33", we, wdata);
        end
        step();
        @(negedge clk);
        total++;
        if (we !== 32'h80 || wdata !== 64'h77 || count !== 2'd1) begin
            bad++;
            $display("FAIL stall_drain1: we=%h wdata=%h count=%0d, required 80/77/1", we, wdata, count);
        end
        step();
        @(negedge clk);
        total++;
        if (we !== 32'h0 || count !== 2'd0) begin
            bad++;
            $display("FAIL stall_third_dropped: we=%h count=%0d, required 0/0", we, count);
        end
    endtask

    task automatic test_xzr();
        step();
        rf_stall = 1'b0; rd_addr = 5'd31;
        in_valid = 1'b1; in_addr = 5'd31; in_data = 64'hFF;
        @(negedge clk);
        total++;
        if (we !== 32'h0 || fwd_hit !== 1'b0) begin
            bad++;
            $display("FAIL xzr_accept: we=%h fwd_hit=%b, required 0/0", we, fwd_hit);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (we !== 32'h0 || count !== 2'd1 || fwd_hit !== 1'b0 || fwd_data !== 64'h0) begin
            bad++;
            $display("FAIL xzr_pending: we=%h count=%0d fwd_hit=%b fwd_data=%h, required 0/1/0/0",
                     we, count, fwd_hit, fwd_data);
        end
        step();
        @(negedge clk);
        total++;
        if (we !== 32'h0 || count !== 2'd0) begin
            bad++;
            $display("FAIL xzr_drain: we=%h count=%0d, required 0/0", we, count);
        end
    endtask

    task automatic test_forward();
        step();
        rf_stall = 1'b1;
        in_valid = 1'b1; in_addr = 5'd9; in_data = 64'h11;
        step();
        in_data = 64'h22;
        step();
        in_valid = 1'b0; rd_addr = 5'd9;
        @(negedge clk);
        total++;
        if (fwd_hit !== 1'b1 || fwd_data !== 64'h22) begin
            bad++;
            $display("FAIL fwd_newest: fwd_hit=%b fwd_data=%h, required 1/22", fwd_hit, fwd_data);
        end
        rd_addr = 5'd10;
        #1;
        total++;
        if (fwd_hit !== 1'b0 || fwd_data !== 64'h0) begin
            bad++;
            $display("FAIL fwd_miss: fwd_hit=%b fwd_data=%h, required 0/0", fwd_hit, fwd_data);
        end
        step();
        rf_stall = 1'b0; rd_addr = 5'd9;
        @(negedge clk);
        total++;
        if (fwd_hit !== 1'b1 || fwd_data !== 64'h22 || we !== 32'h200 || wdata !== 64'h11) begin
            bad++;
            $display("FAIL fwd_issue0: fwd_hit=%b fwd_data=%h we=%h wdata=%h, required 1/22/200/11",
                     fwd_hit, fwd_data, we, wdata);
        end
        step();
        @(negedge clk);
        total++;
        if (fwd_hit !== 1'b1 || fwd_data !== 64'h22 || we !== 32'h200 || wdata !== 64'h22) begin
            bad++;
            $display("FAIL fwd_issue1: fwd_hit=%b fwd_data=%h we=%h wdata=%h, required 1/22/200/22",
                     fwd_hit, fwd_data, we, wdata);
        end
        step();
        @(negedge clk);
        total++;
        if (fwd_hit !== 1'b0 || count !== 2'd0) begin
            bad++;
            $display("FAIL fwd_empty: fwd_hit=%b count=%0d, required 0/0", fwd_hit, count);
        end
    endtask

    task automatic test_reset_mid();
        step();
        rf_stall = 1'b1;
        in_valid = 1'b1; in_addr = 5'd1; in_data = 64'hA1;
        step();
        in_addr = 5'd2; in_data = 64'hA2;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (count !== 2'd2) begin
            bad++;
            $display("FAIL mid_fill: count=%0d, required 2", count);
        end
        step();
        reset = 1'b1; rf_stall = 1'b0; rd_addr = 5'd1;
        @(negedge clk);
        total++;
        if (we !== 32'h0 || in_ready !== 1'b0 || fwd_hit !== 1'b0) begin
            bad++;
            $display("FAIL mid_in_reset: we=%h in_ready=%b fwd_hit=%b, required 0/0/0", we, in_ready, fwd_hit);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (we !== 32'h0 || count !== 2'd0 || in_ready !== 1'b1 || wdata !== 64'h0) begin
                bad++;
                $display("FAIL mid_after_reset[%0d]: we=%h count=%0d in_ready=%b wdata=%h, required 0/0/1/0",
                         i, we, count, in_ready, wdata);
            end
            step();
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_we;
        rf_stall = 1'b0;
        for (int i = 0; i <= 31; i++) begin
            in_valid = (i <= 30);
            in_addr  = 5'(i);
            in_data  = 64'(i * 3 + 1);
            @(negedge clk);
            exp_we = (i == 0) ? 32'h0 : (32'h1 << (i - 1));
            total++;
            if (we !== exp_we || count !== ((i == 0) ? 2'd0 : 2'd1) ||
                (i > 0 && wdata !== 64'((i - 1) * 3 + 1))) begin
                bad++;
                $display("FAIL stream[%0d]: we=%h count=%0d wdata=%h, required we=%h count=%0d",
                         i, we, count, wdata, exp_we, (i == 0) ? 0 : 1);
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (we !== 32'h0 || count !== 2'd0) begin
            bad++;
            $display("FAIL stream_end: we=%h count=%0d, required 0/0", we, count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall_fill();
        test_xzr();
        test_forward();
        test_reset_mid();
        test_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
